// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {LOAD, RUN, HALT} pc_state_t;

  localparam int INST_BYTES = 4;

endpackage

// File: rtl/pc_ctrl.sv
// Program-counter controller: streams a program into instruction memory, then
// sequences the fetch PC. Optional misaligned-redirect trap: PC_CTRL_MISALIGN_TRAP_EN.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ILEN       = 32,
  parameter int IMEM_DEPTH = 1024
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [ILEN-1:0] load_data,
  input  logic            load_last,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  input  logic            restart,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] wdata,
  output logic            write_en,
  output logic            running,
  output logic            load_error,
  output logic            fault
);

  localparam logic [XLEN-1:0] STEP      = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] LAST_ADDR = XLEN'((IMEM_DEPTH - 1) * INST_BYTES);

  pc_state_t       state, state_next;
  logic [XLEN-1:0] pc_next;
  logic            load_error_next;
  logic            misaligned;

  assign misaligned = |redirect_pc[1:0];

`ifdef PC_CTRL_MISALIGN_TRAP_EN
  logic fault_next;
`else
  logic unused_align;
  assign unused_align = misaligned;
  assign fault        = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      pc         <= '0;
      load_error <= 1'b0;
`ifdef PC_CTRL_MISALIGN_TRAP_EN
      fault      <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      load_error <= load_error_next;
`ifdef PC_CTRL_MISALIGN_TRAP_EN
      fault      <= fault_next;
`endif
    end
  end

  // write_en is gated by reset so the memory strobe drops the instant reset rises
  assign load_ready = (state == LOAD);
  assign write_en   = (state == LOAD) && load_valid && !reset;
  assign wdata      = (state == LOAD) ? load_data : '0;
  assign running    = (state == RUN);

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    load_error_next = load_error;
`ifdef PC_CTRL_MISALIGN_TRAP_EN
    fault_next      = fault;
`endif
    case (state)
      LOAD: begin
        if (load_valid) begin
          if (load_last) begin
            pc_next    = '0;
            state_next = RUN;
          end else if (pc == LAST_ADDR) begin
            load_error_next = 1'b1;
            state_next      = HALT;
          end else begin
            pc_next = pc + STEP;
          end
        end
      end
      RUN: begin
        if (halt) begin
          state_next = HALT;
        end else if (redirect_en) begin
`ifdef PC_CTRL_MISALIGN_TRAP_EN
          if (misaligned) begin
            fault_next = 1'b1;
            state_next = HALT;
          end else begin
            pc_next = redirect_pc;
          end
`else
          pc_next = {redirect_pc[XLEN-1:2], 2'b00};
`endif
        end else if (!stall) begin
          pc_next = pc + STEP;
        end
      end
      HALT: begin
`ifdef PC_CTRL_MISALIGN_TRAP_EN
        if (restart && !load_error && !fault) begin
`else
        if (restart && !load_error) begin
`endif
          pc_next    = '0;
          state_next = RUN;
        end
      end
      default: begin
        state_next = LOAD;
        pc_next    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl: a full-size instance and a 4-word instance.
module tb_pc_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        restart = 1'b0;

  logic        load_ready, write_en, running, load_error, fault;
  logic [31:0] pc, wdata;
  logic        s_load_ready, s_write_en, s_running, s_load_error, s_fault;
  logic [31:0] s_pc, s_wdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  pc_ctrl #(.XLEN(32), .ILEN(32), .IMEM_DEPTH(1024)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halt(halt),
    .restart(restart), .pc(pc), .wdata(wdata), .write_en(write_en),
    .running(running), .load_error(load_error), .fault(fault)
  );

  pc_ctrl #(.XLEN(32), .ILEN(32), .IMEM_DEPTH(4)) dut_small (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(s_load_ready),
    .load_data(load_data), .load_last(load_last), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halt(halt),
    .restart(restart), .pc(s_pc), .wdata(s_wdata), .write_en(s_write_en),
    .running(s_running), .load_error(s_load_error), .fault(s_fault)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    load_valid  = 1'b0;
    load_data   = '0;
    load_last   = 1'b0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    restart     = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 0", pc); end
    vectors++;
    if (load_ready !== 1'b1 || running !== 1'b0) begin
      miscompares++; $display("FAIL reset_state ready=%b running=%b want 1/0", load_ready, running);
    end
    vectors++;
    if (load_error !== 1'b0 || fault !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags load_error=%b fault=%b want 0/0", load_error, fault);
    end
  endtask

  task automatic test_load();
    logic [31:0] prog [3];
    prog[0] = 32'h00500093;
    prog[1] = 32'h00A00113;
    prog[2] = 32'h002081B3;
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_data = prog[i];
      load_last = (i == 2);
      #1;
      vectors++;
      if (write_en !== 1'b1 || pc !== 32'(i * 4) || wdata !== prog[i]) begin
        miscompares++;
        $display("FAIL load_beat%0d we=%b pc=%h wdata=%h want 1/%h/%h", i, write_en, pc, wdata, 32'(i * 4), prog[i]);
      end
      tick();
    end
    vectors++;
    if (running !== 1'b1 || pc !== 32'h0) begin
      miscompares++; $display("FAIL load_to_run running=%b pc=%h want 1/0", running, pc);
    end
    vectors++;
    if (write_en !== 1'b0 || load_ready !== 1'b0 || wdata !== 32'h0) begin
      miscompares++; $display("FAIL run_strobes we=%b ready=%b wdata=%h want 0/0/0", write_en, load_ready, wdata);
    end
    clear_inputs();
  endtask

  task automatic test_run_stall_redirect();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (pc !== 32'(k * 4)) begin miscompares++; $display("FAIL run_inc%0d pc=%h want %h", k, pc, 32'(k * 4)); end
      if (k < 3) tick();
    end
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (pc !== 32'hC) begin miscompares++; $display("FAIL stall%0d pc=%h want c", k, pc); end
    end
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    tick();
    vectors++;
    if (pc !== 32'h40 || running !== 1'b1) begin
      miscompares++; $display("FAIL redirect_over_stall pc=%h running=%b want 40/1", pc, running);
    end
    stall       = 1'b0;
    redirect_pc = 32'h80;
    halt        = 1'b1;
    tick();
    vectors++;
    if (pc !== 32'h40 || running !== 1'b0) begin
      miscompares++; $display("FAIL halt_over_redirect pc=%h running=%b want 40/0", pc, running);
    end
    clear_inputs();
    tick();
    vectors++;
    if (pc !== 32'h40 || running !== 1'b0 || write_en !== 1'b0) begin
      miscompares++; $display("FAIL halt_hold pc=%h running=%b we=%b want 40/0/0", pc, running, write_en);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    vectors++;
    if (pc !== 32'h0 || running !== 1'b1) begin
      miscompares++; $display("FAIL restart pc=%h running=%b want 0/1", pc, running);
    end
  endtask

  task automatic test_misalign();
    redirect_en = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_en = 1'b0;
`ifdef PC_CTRL_MISALIGN_TRAP_EN
    vectors++;
    if (fault !== 1'b1 || running !== 1'b0 || pc !== 32'h0) begin
      miscompares++; $display("FAIL misalign_trap fault=%b running=%b pc=%h want 1/0/0", fault, running, pc);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    vectors++;
    if (running !== 1'b0 || fault !== 1'b1) begin
      miscompares++; $display("FAIL fault_restart running=%b fault=%b want 0/1", running, fault);
    end
`else
    vectors++;
    if (pc !== 32'h40 || running !== 1'b1 || fault !== 1'b0) begin
      miscompares++; $display("FAIL misalign_force pc=%h running=%b fault=%b want 40/1/0", pc, running, fault);
    end
    tick();
    vectors++;
    if (pc !== 32'h44) begin miscompares++; $display("FAIL misalign_continue pc=%h want 44", pc); end
`endif
  endtask

  task automatic test_overflow();
    test_reset();
    load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_data = 32'(i + 1);
      #1;
      vectors++;
      if (s_write_en !== 1'b1 || s_pc !== 32'(i * 4)) begin
        miscompares++; $display("FAIL ovf_beat%0d we=%b pc=%h want 1/%h", i, s_write_en, s_pc, 32'(i * 4));
      end
      tick();
    end
    vectors++;
    if (s_load_error !== 1'b1 || s_running !== 1'b0) begin
      miscompares++; $display("FAIL ovf_error load_error=%b running=%b want 1/0", s_load_error, s_running);
    end
    vectors++;
    if (s_load_ready !== 1'b0 || s_write_en !== 1'b0) begin
      miscompares++; $display("FAIL ovf_5th_beat ready=%b we=%b want 0/0", s_load_ready, s_write_en);
    end
    clear_inputs();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    vectors++;
    if (s_running !== 1'b0 || s_load_error !== 1'b1) begin
      miscompares++; $display("FAIL ovf_restart running=%b load_error=%b want 0/1", s_running, s_load_error);
    end
    vectors++;
    if (load_error !== 1'b0 || pc !== 32'h10) begin
      miscompares++; $display("FAIL big_no_error load_error=%b pc=%h want 0/10", load_error, pc);
    end
  endtask

  task automatic test_reset_mid_load();
    test_reset();
    load_valid = 1'b1;
    load_data  = 32'h11111111;
    tick();
    load_data  = 32'h22222222;
    tick();
    vectors++;
    if (pc !== 32'h8) begin miscompares++; $display("FAIL midload_pc pc=%h want 8", pc); end
    #3 reset = 1'b1;
    #1;
    vectors++;
    if (pc !== 32'h0 || write_en !== 1'b0) begin
      miscompares++; $display("FAIL async_reset pc=%h we=%b want 0/0", pc, write_en);
    end
    vectors++;
    if (load_ready !== 1'b1 || running !== 1'b0) begin
      miscompares++; $display("FAIL async_reset_state ready=%b running=%b want 1/0", load_ready, running);
    end
    #2 reset = 1'b0;
    load_data = 32'h00000013;
    load_last = 1'b1;
    #1;
    vectors++;
    if (write_en !== 1'b1 || pc !== 32'h0) begin
      miscompares++; $display("FAIL reload_beat we=%b pc=%h want 1/0", write_en, pc);
    end
    tick();
    vectors++;
    if (running !== 1'b1 || pc !== 32'h0) begin
      miscompares++; $display("FAIL reload_run running=%b pc=%h want 1/0", running, pc);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_stall_redirect();
    test_misalign();
    test_overflow();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
